// File: rtl/scanner_commander_if.sv
// Host/scanner signal bundle for scanner_commander.
// slave: the commander itself; master: the host and scanner side that drives it.
interface scanner_commander_if;
    logic       host_req;
    logic       host_flush;
    logic       host_clr;
    logic [2:0] scan_state;
    logic [3:0] scan_prog;
    logic       goToStandby;
    logic       startScan;
    logic       startTransfer;
    logic       flush;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_code;

    modport slave (
        input  host_req, host_flush, host_clr, scan_state, scan_prog,
        output goToStandby, startScan, startTransfer, flush, busy, done, fault, fault_code
    );

    modport master (
        output host_req, host_flush, host_clr, scan_state, scan_prog,
        input  goToStandby, startScan, startTransfer, flush, busy, done, fault, fault_code
    );
endinterface

// File: rtl/scanner_commander.sv
// scanner_commander: host-side initiator that walks one scanner through
// wake -> scan -> transfer/flush -> low power, supervising every wait with a timeout.
// Optional macro PROG_CHECK_EN adds monotonic progress checking (fault code 11).
module scanner_commander #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned PROG_FULL      = 10
) (
    input logic                 clk,
    input logic                 reset,
    scanner_commander_if.slave  bus
);

    typedef enum logic [3:0] {
        StIdle, StWake, StWaitSb, StStart, StWaitScan, StDecide, StWaitDrain, StFinish, StFault
    } state_e;

    localparam logic [2:0] ScLowPower = 3'b000;
    localparam logic [2:0] ScStandby  = 3'b001;
    localparam logic [2:0] ScScanning = 3'b010;
    localparam logic [2:0] ScIdle     = 3'b011;
    localparam logic [2:0] ScXfer     = 3'b100;
    localparam logic [2:0] ScFlush    = 3'b101;

    localparam logic [1:0] CodeNone    = 2'b00;
    localparam logic [1:0] CodeTimeout = 2'b01;
    localparam logic [1:0] CodeState   = 2'b10;
    localparam logic [1:0] CodeProg    = 2'b11;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] ProgFull    = 4'(PROG_FULL);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       flush_flag_q, flush_flag_d;
    logic [1:0] code_q, code_d;
    logic       gts_q, gts_d;
    logic       start_q, start_d;
    logic       xfer_q, xfer_d;
    logic       flush_q, flush_d;
    logic       timed_out;
    logic       prog_bad;

    // The wait that started at timer 0 has now spent TIMEOUT_CYCLES cycles.
    assign timed_out = (timer_q == TimeoutLast);

`ifdef PROG_CHECK_EN
    logic [3:0] prog_q;

    // Previous-cycle progress sample for step checking.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_q <= 4'd0;
        end else begin
            prog_q <= bus.scan_prog;
        end
    end

    // Flag any progress change that is not a legal single step for the current phase.
    always_comb begin
        prog_bad = 1'b0;
        if (bus.scan_prog != prog_q) begin
            if (state_q == StWaitScan) begin
                prog_bad = !((prog_q < ProgFull) && (bus.scan_prog == prog_q + 4'd1));
            end else if (state_q == StWaitDrain) begin
                if ((bus.scan_state == ScXfer) || (bus.scan_state == ScFlush)) begin
                    prog_bad = !((prog_q != 4'd0) && (bus.scan_prog == prog_q - 4'd1));
                end else begin
                    prog_bad = 1'b1;
                end
            end
        end
    end
`else
    assign prog_bad = 1'b0;
`endif

    // State, timer, latched flag, fault code and registered command pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            timer_q      <= 8'd0;
            flush_flag_q <= 1'b0;
            code_q       <= CodeNone;
            gts_q        <= 1'b0;
            start_q      <= 1'b0;
            xfer_q       <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            flush_flag_q <= flush_flag_d;
            code_q       <= code_d;
            gts_q        <= gts_d;
            start_q      <= start_d;
            xfer_q       <= xfer_d;
            flush_q      <= flush_d;
        end
    end

    // Next-state logic; state/progress faults take priority, exit beats timeout.
    always_comb begin
        state_d      = state_q;
        flush_flag_d = flush_flag_q;
        code_d       = code_q;
        gts_d        = 1'b0;
        start_d      = 1'b0;
        xfer_d       = 1'b0;
        flush_d      = 1'b0;
        timer_d      = timer_q;

        unique case (state_q)
            StIdle: begin
                if (bus.host_req) begin
                    flush_flag_d = bus.host_flush;
                    state_d      = StWake;
                end
            end
            StWake: begin
                if (bus.scan_state == ScLowPower) begin
                    gts_d   = 1'b1;
                    state_d = StWaitSb;
                end else begin
                    code_d  = CodeState;
                    state_d = StFault;
                end
            end
            StWaitSb: begin
                if (bus.scan_state == ScStandby) begin
                    state_d = StStart;
                end else if (timed_out) begin
                    code_d  = CodeTimeout;
                    state_d = StFault;
                end
            end
            StStart: begin
                start_d = 1'b1;
                state_d = StWaitScan;
            end
            StWaitScan: begin
                if (!((bus.scan_state == ScStandby) || (bus.scan_state == ScScanning) ||
                      ((bus.scan_state == ScIdle) && (bus.scan_prog == ProgFull)))) begin
                    code_d  = CodeState;
                    state_d = StFault;
                end else if (prog_bad) begin
                    code_d  = CodeProg;
                    state_d = StFault;
                end else if (bus.scan_state == ScIdle) begin
                    state_d = StDecide;
                end else if (timed_out) begin
                    code_d  = CodeTimeout;
                    state_d = StFault;
                end
            end
            StDecide: begin
                flush_d = flush_flag_q;
                xfer_d  = !flush_flag_q;
                state_d = StWaitDrain;
            end
            StWaitDrain: begin
                if (!((bus.scan_state == ScIdle) || (bus.scan_state == ScXfer) ||
                      (bus.scan_state == ScFlush) || (bus.scan_state == ScLowPower))) begin
                    code_d  = CodeState;
                    state_d = StFault;
                end else if (prog_bad) begin
                    code_d  = CodeProg;
                    state_d = StFault;
                end else if (bus.scan_state == ScLowPower) begin
                    state_d = StFinish;
                end else if (timed_out) begin
                    code_d  = CodeTimeout;
                    state_d = StFault;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            StFault: begin
                if (bus.host_clr) begin
                    code_d  = CodeNone;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = 8'd0;
        end else if ((state_q == StWaitSb) || (state_q == StWaitScan) ||
                     (state_q == StWaitDrain)) begin
            timer_d = timer_q + 8'd1;
        end
    end

    assign bus.goToStandby   = gts_q;
    assign bus.startScan     = start_q;
    assign bus.startTransfer = xfer_q;
    assign bus.flush         = flush_q;
    assign bus.busy          = (state_q != StIdle) && (state_q != StFault);
    assign bus.done          = (state_q == StFinish);
    assign bus.fault         = (state_q == StFault);
    assign bus.fault_code    = code_q;

endmodule

// File: tb/tb_scanner_commander.sv
// Self-checking bench for scanner_commander: per-cycle vector table plus a
// hand-written progress-jump sequence.
module tb_scanner_commander;

    localparam int unsigned Timeout = 64;

    // Expected output vector: {gts, startScan, startTransfer, flush, busy, done, fault, code}.
    localparam logic [8:0] ExGts   = 9'h100;
    localparam logic [8:0] ExSs    = 9'h080;
    localparam logic [8:0] ExSt    = 9'h040;
    localparam logic [8:0] ExFl    = 9'h020;
    localparam logic [8:0] ExBusy  = 9'h010;
    localparam logic [8:0] ExDone  = 9'h008;
    localparam logic [8:0] ExFault = 9'h004;
    localparam logic [8:0] ExCTo   = 9'h001;
    localparam logic [8:0] ExCSt   = 9'h002;
    localparam logic [8:0] ExCPg   = 9'h003;

    typedef struct {
        logic        rst;
        logic        req;
        logic        hflush;
        logic        clr;
        logic [2:0]  st;
        logic [3:0]  pg;
        logic [8:0]  exp;
        logic [95:0] tag;
    } vec_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    vec_t vecs[$];

    scanner_commander_if bus ();

    scanner_commander #(
        .TIMEOUT_CYCLES(Timeout),
        .PROG_FULL     (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic rq, input logic hf, input logic hc,
                       input logic [2:0] s, input logic [3:0] p, input logic [8:0] e,
                       input logic [95:0] tag);
        vec_t v;
        v.rst = r; v.req = rq; v.hflush = hf; v.clr = hc;
        v.st = s; v.pg = p; v.exp = e; v.tag = tag;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, clock, then compare outputs 1 ns after the edge.
    task automatic step(input logic r, input logic rq, input logic hf, input logic hc,
                        input logic [2:0] s, input logic [3:0] p, input logic [8:0] e,
                        input logic [95:0] tag);
        logic [8:0] act;
        reset          = r;
        bus.host_req   = rq;
        bus.host_flush = hf;
        bus.host_clr   = hc;
        bus.scan_state = s;
        bus.scan_prog  = p;
        @(posedge clk);
        #1;
        act = {bus.goToStandby, bus.startScan, bus.startTransfer, bus.flush,
               bus.busy, bus.done, bus.fault, bus.fault_code};
        n_total++;
        if (act === e) begin
            n_pass++;
        end else begin
            $display("FAIL %0s: outputs=%b required=%b", tag, act, e);
        end
    endtask

    // Full good cycle: wake, scan 0..10, transfer/flush drain 9..0, back to low power.
    task automatic add_cycle(input logic fl);
        add(0, 1, fl, 0, 3'b000, 4'd0, ExBusy, "req");
        add(0, 0, 0, 0, 3'b000, 4'd0, ExGts | ExBusy, "wake");
        add(0, 0, 0, 0, 3'b001, 4'd0, ExBusy, "wait_sb");
        add(0, 0, 0, 0, 3'b001, 4'd0, ExSs | ExBusy, "start");
        for (int p = 0; p < 10; p++) add(0, 1, 0, 0, 3'b010, 4'(p), ExBusy, "scan");
        add(0, 0, 0, 0, 3'b011, 4'd10, ExBusy, "scan_end");
        add(0, 0, 0, 0, 3'b011, 4'd10, (fl ? ExFl : ExSt) | ExBusy, "decide");
        for (int p = 9; p >= 0; p--) begin
            add(0, 0, 0, 0, fl ? 3'b101 : 3'b100, 4'(p), ExBusy, "drain");
        end
        add(0, 0, 0, 0, 3'b000, 4'd0, ExBusy | ExDone, "finish");
        add(0, 0, 0, 0, 3'b000, 4'd0, 9'h000, "idle");
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        add(1, 0, 0, 0, 3'b000, 4'd0, 9'h000, "reset");
        add(1, 1, 1, 1, 3'b000, 4'd0, 9'h000, "reset_hold");
        add(0, 0, 0, 0, 3'b000, 4'd0, 9'h000, "idle0");
        add_cycle(1'b0);
        add_cycle(1'b1);

        // Scanner never reaches standby: timeout after exactly Timeout cycles in WAIT_SB.
        add(0, 1, 0, 0, 3'b000, 4'd0, ExBusy, "req_to");
        add(0, 0, 0, 0, 3'b000, 4'd0, ExGts | ExBusy, "wake_to");
        for (int k = 1; k < int'(Timeout); k++) add(0, 0, 0, 0, 3'b000, 4'd0, ExBusy, "sb_wait");
        add(0, 0, 0, 0, 3'b000, 4'd0, ExFault | ExCTo, "timeout");
        add(0, 0, 0, 1, 3'b000, 4'd0, 9'h000, "clr_to");

        // Exit on the same cycle the timer expires: exit wins.
        add(0, 1, 0, 0, 3'b000, 4'd0, ExBusy, "req_ew");
        add(0, 0, 0, 0, 3'b000, 4'd0, ExGts | ExBusy, "wake_ew");
        for (int k = 1; k < int'(Timeout); k++) add(0, 0, 0, 0, 3'b000, 4'd0, ExBusy, "sb_wait2");
        add(0, 0, 0, 0, 3'b001, 4'd0, ExBusy, "exit_wins");
        add(0, 0, 0, 0, 3'b001, 4'd0, ExSs | ExBusy, "start_ew");
        add(0, 0, 0, 0, 3'b101, 4'd0, ExFault | ExCSt, "scan_bad");
        add(0, 0, 0, 1, 3'b000, 4'd0, 9'h000, "clr_ew");

        // Unexpected transfer state during scan; req ignored in FAULT, clr wins.
        add(0, 1, 0, 0, 3'b000, 4'd0, ExBusy, "req_u");
        add(0, 0, 0, 0, 3'b000, 4'd0, ExGts | ExBusy, "wake_u");
        add(0, 0, 0, 0, 3'b001, 4'd0, ExBusy, "sb_u");
        add(0, 0, 0, 0, 3'b001, 4'd0, ExSs | ExBusy, "start_u");
        for (int p = 0; p < 3; p++) add(0, 0, 0, 0, 3'b010, 4'(p), ExBusy, "scan_u");
        add(0, 0, 0, 0, 3'b100, 4'd3, ExFault | ExCSt, "unexpected");
        add(0, 1, 0, 0, 3'b000, 4'd3, ExFault | ExCSt, "fault_hold");
        add(0, 1, 0, 1, 3'b000, 4'd0, 9'h000, "clr_req");
        add(0, 0, 0, 0, 3'b000, 4'd0, 9'h000, "idle_u");

        // Scanner not in low power at wake.
        add(0, 1, 0, 0, 3'b011, 4'd0, ExBusy, "req_w");
        add(0, 0, 0, 0, 3'b011, 4'd0, ExFault | ExCSt, "wake_bad");
        add(0, 0, 0, 1, 3'b000, 4'd0, 9'h000, "clr_w");

        // Reset in WAIT_DRAIN, then a clean cycle.
        add(0, 1, 0, 0, 3'b000, 4'd0, ExBusy, "req_r");
        add(0, 0, 0, 0, 3'b000, 4'd0, ExGts | ExBusy, "wake_r");
        add(0, 0, 0, 0, 3'b001, 4'd0, ExBusy, "sb_r");
        add(0, 0, 0, 0, 3'b001, 4'd0, ExSs | ExBusy, "start_r");
        for (int p = 0; p < 10; p++) add(0, 0, 0, 0, 3'b010, 4'(p), ExBusy, "scan_r");
        add(0, 0, 0, 0, 3'b011, 4'd10, ExBusy, "scan_end_r");
        add(0, 0, 0, 0, 3'b011, 4'd10, ExSt | ExBusy, "decide_r");
        add(0, 0, 0, 0, 3'b100, 4'd9, ExBusy, "drain_r");
        add(1, 0, 0, 0, 3'b100, 4'd8, 9'h000, "rst_mid");
        add(0, 0, 0, 0, 3'b000, 4'd0, 9'h000, "post_rst");
        add_cycle(1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].hflush, vecs[i].clr,
                 vecs[i].st, vecs[i].pg, vecs[i].exp, vecs[i].tag);
        end

        // Progress jumps 3 -> 5 while scanning.
        step(0, 1, 0, 0, 3'b000, 4'd0, ExBusy, "req_p");
        step(0, 0, 0, 0, 3'b000, 4'd0, ExGts | ExBusy, "wake_p");
        step(0, 0, 0, 0, 3'b001, 4'd0, ExBusy, "sb_p");
        step(0, 0, 0, 0, 3'b001, 4'd0, ExSs | ExBusy, "start_p");
        for (int p = 0; p < 4; p++) step(0, 0, 0, 0, 3'b010, 4'(p), ExBusy, "scan_p");
`ifdef PROG_CHECK_EN
        step(0, 0, 0, 0, 3'b010, 4'd5, ExFault | ExCPg, "prog_jump");
`else
        step(0, 0, 0, 0, 3'b010, 4'd5, ExBusy, "prog_jump");
        step(0, 0, 0, 0, 3'b101, 4'd5, ExFault | ExCSt, "scan_bad_p");
`endif
        step(0, 0, 0, 1, 3'b000, 4'd0, 9'h000, "clr_p");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
